multi_sync_debounce: RTL and testbench



---
 rtl/multi_sync_debounce.sv | 131 +++++++++++++
 tb/tb_multi_sync_debounce.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/multi_sync_debounce.sv
// rtl/multi_sync_debounce.sv - multi-channel synchronizer with optional debounce and edge pulses
//
// Purpose:
//   Brings WIDTH independent asynchronous inputs into the clk domain through
//   a STAGES-deep flop chain per channel.  When SYNC_DEBOUNCE_EN is defined,
//   each channel also needs DB_CYCLES consecutive stable cycles before its
//   level changes.  Registered rise/fall pulses mark every level transition.
//
// Optional feature macro: SYNC_DEBOUNCE_EN
//   defined   - per-channel debounce counters present, busy is live
//   undefined - level follows the sync chain output directly, busy tied 0
//
// Ports:
//   clk     in   1      system clock, all state on posedge
//   rst_n   in   1      asynchronous active-low reset
//   sig_in  in   WIDTH  raw asynchronous inputs, one bit per channel
//   level   out  WIDTH  clean registered level per channel
//   rise    out  WIDTH  one-cycle pulse when level goes 0->1
//   fall    out  WIDTH  one-cycle pulse when level goes 1->0
//   busy    out  1      some channel has a nonzero debounce count

module multi_sync_debounce #(
   parameter int               WIDTH     = 1,
   parameter int               STAGES    = 2,
   parameter int               DB_CYCLES = 16,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sig_in,
   output logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             busy
);

   if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("multi_sync_debounce: STAGES must be in 2..4");
   end
   if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db_cycles
      $error("multi_sync_debounce: DB_CYCLES must be in 1..65535");
   end

   // Synchronizer chain: plain flop-to-flop, nothing in between.
   logic [WIDTH-1:0] stage [STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] level_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            stage[k] <= RESET_VAL;
         end
      end else begin
         stage[0] <= sig_in;
         for (int k = 1; k < STAGES; k++) begin
            stage[k] <= stage[k-1];
         end
      end
   end

   assign sync = stage[STAGES-1];

`ifdef SYNC_DEBOUNCE_EN
   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [CW-1:0] cnt      [WIDTH];
   logic [CW-1:0] cnt_next [WIDTH];

   // A channel only moves after CNT_LAST+1 consecutive disagreeing cycles;
   // any agreeing cycle throws the partial count away, so the counter
   // tops out at CNT_LAST and cannot wrap.
   always_comb begin
      level_next = level;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next[i] = '0;
         if (sync[i] == level[i]) begin
            cnt_next[i] = '0;
         end else if (cnt[i] == CNT_LAST) begin
            level_next[i] = sync[i];
            cnt_next[i]   = '0;
         end else begin
            cnt_next[i] = cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= cnt_next[i];
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (cnt[i] != '0) begin
            busy = 1'b1;
         end
      end
   end
`else
   always_comb begin
      level_next = sync;
   end

   assign busy = 1'b0;
`endif

   // Edge pulses are registered on the same edge that updates level, so a
   // pulse lines up with the first cycle the new level is visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= RESET_VAL;
         rise  <= '0;
         fall  <= '0;
      end else begin
         level <= level_next;
         rise  <= level_next & ~level;
         fall  <= ~level_next & level;
      end
   end

endmodule

// File: tb/tb_multi_sync_debounce.sv
// tb/tb_multi_sync_debounce.sv - directed table-driven bench for multi_sync_debounce

module tb_multi_sync_debounce;

   localparam int W  = 4;
   localparam int ST = 2;
   localparam int DB = 4;
`ifdef SYNC_DEBOUNCE_EN
   localparam bit DBE = 1'b1;
`else
   localparam bit DBE = 1'b0;
`endif
   // Edge (counting the edge that first samples a new input as 1) at which
   // level shows the new value.
   localparam int E = ST + (DBE ? DB - 1 : 0) + 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] sig_in;
   logic [W-1:0] level, rise, fall;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [W-1:0] model_level;

   multi_sync_debounce #(
      .WIDTH(W), .STAGES(ST), .DB_CYCLES(DB), .RESET_VAL(4'b0000)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sig_in(sig_in),
      .level(level), .rise(rise), .fall(fall), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive a new input pattern and check every cycle until the pulse has gone.
   task automatic apply(input logic [W-1:0] sig, input logic [W-1:0] exp_level,
                        input logic [W-1:0] exp_rise, input logic [W-1:0] exp_fall);
      logic [W-1:0] changed;
      changed = sig ^ model_level;
      @(negedge clk);
      sig_in = sig;
      for (int e = 1; e <= E + 1; e++) begin
         @(posedge clk);
         #1;
         check("level", level, (e >= E) ? exp_level : model_level);
         check("rise", rise, (e == E) ? exp_rise : '0);
         check("fall", fall, (e == E) ? exp_fall : '0);
         check("busy", busy, (DBE && changed != 0 && e >= ST + 1 && e <= E - 1) ? 1 : 0);
      end
      model_level = exp_level;
   endtask

   typedef struct {
      logic [W-1:0] sig;
      logic [W-1:0] lvl;
      logic [W-1:0] rs;
      logic [W-1:0] fl;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int rises, falls, highs, busys, last_rise;

      vecs[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
      vecs[1] = '{4'b0011, 4'b0011, 4'b0010, 4'b0000};
      vecs[2] = '{4'b0010, 4'b0010, 4'b0000, 4'b0001};
      vecs[3] = '{4'b1001, 4'b1001, 4'b1001, 4'b0010};
      vecs[4] = '{4'b1001, 4'b1001, 4'b0000, 4'b0000};
      vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b1001};
      vecs[6] = '{4'b1111, 4'b1111, 4'b1111, 4'b0000};
      vecs[7] = '{4'b0101, 4'b0101, 4'b0000, 4'b1010};

      // Reset held with all inputs high.
      rst_n  = 1'b0;
      sig_in = 4'b1111;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("rst_level", level, 0);
         check("rst_rise", rise, 0);
         check("rst_fall", fall, 0);
         check("rst_busy", busy, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      model_level = 4'b0000;
      for (int e = 1; e <= E + 1; e++) begin
         @(posedge clk);
         #1;
         check("rel_level", level, (e >= E) ? 4'b1111 : 4'b0000);
         check("rel_rise", rise, (e == E) ? 4'b1111 : 4'b0000);
         check("rel_fall", fall, 0);
      end
      model_level = 4'b1111;
      apply(4'b0000, 4'b0000, 4'b0000, 4'b1111);

      // Table of level steps, including simultaneous rise/fall across channels.
      for (int v = 0; v < 8; v++) begin
         apply(vecs[v].sig, vecs[v].lvl, vecs[v].rs, vecs[v].fl);
      end
      apply(4'b0000, 4'b0000, 4'b0000, 4'b0101);

      // Three-cycle glitch on channel 1.
      rises = 0; falls = 0; highs = 0; busys = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         sig_in = (c < 3) ? 4'b0010 : 4'b0000;
         @(posedge clk);
         #1;
         if (rise[1]) rises++;
         if (fall[1]) falls++;
         if (level[1]) highs++;
         if (busy) busys++;
      end
      check("glitch_rise", rises, DBE ? 0 : 1);
      check("glitch_fall", falls, DBE ? 0 : 1);
      check("glitch_high", highs, DBE ? 0 : 3);
      check("glitch_busy", busys, DBE ? 3 : 0);
      check("glitch_busy_end", busy, 0);

      // Channel 2 bounces every 2 cycles, then holds high from index 20.
      rises = 0; falls = 0; last_rise = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         sig_in = 4'b0000;
         sig_in[2] = (c < 20) ? (((c / 2) % 2) == 0) : 1'b1;
         @(posedge clk);
         #1;
         if (rise[2]) begin
            rises++;
            last_rise = c;
         end
         if (fall[2]) falls++;
      end
      check("bounce_rises", rises, DBE ? 1 : 6);
      check("bounce_falls", falls, DBE ? 0 : 5);
      check("bounce_rise_when", last_rise, 20 + E - 1);
      check("bounce_level", level, 4'b0100);

      // Reset in the middle of a count on channel 0.
      @(negedge clk);
      sig_in = 4'b0101;
      repeat (4) @(posedge clk);
      #1;
      if (DBE) check("mid_busy", busy, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_level", level, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rise", rise, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_level = 4'b0000;
      for (int e = 1; e <= E + 1; e++) begin
         @(posedge clk);
         #1;
         check("mid_rel_level", level, (e >= E) ? 4'b0101 : 4'b0000);
         check("mid_rel_rise", rise, (e == E) ? 4'b0101 : 4'b0000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
